// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dm_arbiter
//  Description : Access controller and two-port arbiter in front of a
//                word-only data memory (1024 x 32, combinational read,
//                synchronous write). Arbitrates between the CPU M-stage
//                port (C) and the loader/debug port (D), turns byte and
//                halfword stores into read-modify-write sequences, extracts
//                zero-extended sub-word loads and rejects misaligned or
//                out-of-range accesses without a memory cycle.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    MEM_BYTES   legal byte addresses are [0, MEM_BYTES-1]
//    RESET_PRIO  requester that wins the first tie after reset (0=C, 1=D)
//  Optional feature
//    DM_ARBITER_TRACE_EN  when defined, prints a line for every memory
//                         write and for every rejected access
//  Ports
//    clk, rst_n                        clock, asynchronous active-low reset
//    i_c_req/we/size/addr/wd/pc        C request (held until o_c_ack)
//    o_c_ack/err/rdata                 C completion pulse, error, load data
//    i_d_* / o_d_*                     same set for requester D
//    o_mem_a/we/wd/pc, i_mem_rd        word memory interface
//    o_busy                            controller not idle
// ============================================================================
module dm_arbiter #(
   parameter int unsigned MEM_BYTES  = 4096,
   parameter bit          RESET_PRIO = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   // requester C
   input  logic        i_c_req,
   input  logic        i_c_we,
   input  logic [1:0]  i_c_size,
   input  logic [31:0] i_c_addr,
   input  logic [31:0] i_c_wd,
   input  logic [31:0] i_c_pc,
   output logic        o_c_ack,
   output logic        o_c_err,
   output logic [31:0] o_c_rdata,
   // requester D
   input  logic        i_d_req,
   input  logic        i_d_we,
   input  logic [1:0]  i_d_size,
   input  logic [31:0] i_d_addr,
   input  logic [31:0] i_d_wd,
   input  logic [31:0] i_d_pc,
   output logic        o_d_ack,
   output logic        o_d_err,
   output logic [31:0] o_d_rdata,
   // word memory
   output logic [31:0] o_mem_a,
   output logic        o_mem_we,
   output logic [31:0] o_mem_wd,
   output logic [31:0] o_mem_pc,
   input  logic [31:0] i_mem_rd,
   // status
   output logic        o_busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2,
      S_ACK  = 2'd3
   } state_t;

   localparam logic [1:0] c_SZ_BYTE = 2'b00;
   localparam logic [1:0] c_SZ_HALF = 2'b01;
   localparam logic [1:0] c_SZ_WORD = 2'b10;
   localparam logic [1:0] c_SZ_ILL  = 2'b11;

   localparam logic c_OWNER_C = 1'b0;
   localparam logic c_OWNER_D = 1'b1;

   state_t      r_state;
   state_t      w_state_nxt;

   // latched transaction
   logic        r_owner;
   logic        r_we;
   logic        r_err;
   logic [1:0]  r_size;
   logic [31:0] r_addr;
   logic [31:0] r_wd;
   logic [31:0] r_pc;
   logic [31:0] r_buf;     // memory word captured in RD (merge / load source)

   // requester that wins the next tie (0 = C, 1 = D)
   logic        r_prio;

   // arbitration and selected request
   logic        w_grant;
   logic        w_gnt_d;
   logic        w_sel_we;
   logic [1:0]  w_sel_size;
   logic [31:0] w_sel_addr;
   logic [31:0] w_sel_wd;
   logic [31:0] w_sel_pc;
   logic        w_sel_err;

   // lane handling
   logic [31:0] w_merge;
   logic [31:0] w_load;
   logic [31:0] w_rdata;

   // -------------------------------------------------------------------------
   // Arbitration: only sampled in IDLE. D wins when it is alone, or when both
   // ask and D holds the tie-break token.
   // -------------------------------------------------------------------------
   assign w_grant    = (r_state == S_IDLE) && (i_c_req || i_d_req);
   assign w_gnt_d    = i_d_req && (!i_c_req || r_prio);

   assign w_sel_we   = w_gnt_d ? i_d_we   : i_c_we;
   assign w_sel_size = w_gnt_d ? i_d_size : i_c_size;
   assign w_sel_addr = w_gnt_d ? i_d_addr : i_c_addr;
   assign w_sel_wd   = w_gnt_d ? i_d_wd   : i_c_wd;
   assign w_sel_pc   = w_gnt_d ? i_d_pc   : i_c_pc;

   assign w_sel_err  = (w_sel_size == c_SZ_ILL)
                    || ((w_sel_size == c_SZ_HALF) && w_sel_addr[0])
                    || ((w_sel_size == c_SZ_WORD) && (w_sel_addr[1:0] != 2'b00))
                    || (w_sel_addr >= MEM_BYTES);

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Transaction latch, tie-break token and read buffer
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_owner <= c_OWNER_C;
         r_we    <= 1'b0;
         r_err   <= 1'b0;
         r_size  <= 2'b00;
         r_addr  <= 32'd0;
         r_wd    <= 32'd0;
         r_pc    <= 32'd0;
         r_buf   <= 32'd0;
         r_prio  <= RESET_PRIO;
      end else begin
         if (w_grant) begin
            r_owner <= w_gnt_d;
            r_we    <= w_sel_we;
            r_err   <= w_sel_err;
            r_size  <= w_sel_size;
            r_addr  <= w_sel_addr;
            r_wd    <= w_sel_wd;
            r_pc    <= w_sel_pc;
            // the requester just served loses the next tie
            r_prio  <= ~w_gnt_d;
         end
         if (r_state == S_RD) begin
            r_buf <= i_mem_rd;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Little-endian lane merge (stores) and extraction (loads)
   // -------------------------------------------------------------------------
   always_comb begin
      w_merge = r_buf;
      w_load  = r_buf;
      case (r_size)
         c_SZ_BYTE: begin
            w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wd[7:0];
            w_load = {24'd0, r_buf[{r_addr[1:0], 3'b000} +: 8]};
         end
         c_SZ_HALF: begin
            w_merge[{r_addr[1], 4'b0000} +: 16] = r_wd[15:0];
            w_load = {16'd0, r_buf[{r_addr[1], 4'b0000} +: 16]};
         end
         default: begin
            w_merge = r_buf;
            w_load  = r_buf;
         end
      endcase
   end

   // rejected accesses and stores return zero
   assign w_rdata = (r_err || r_we) ? 32'd0 : w_load;

   // -------------------------------------------------------------------------
   // Next state and outputs
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      o_mem_a     = 32'd0;
      o_mem_we    = 1'b0;
      o_mem_wd    = 32'd0;
      o_mem_pc    = 32'd0;
      o_c_ack     = 1'b0;
      o_c_err     = 1'b0;
      o_c_rdata   = 32'd0;
      o_d_ack     = 1'b0;
      o_d_err     = 1'b0;
      o_d_rdata   = 32'd0;
      o_busy      = (r_state != S_IDLE);

      case (r_state)
         S_IDLE: begin
            if (w_grant) begin
               if (w_sel_err) begin
                  w_state_nxt = S_ACK;
               end else if (w_sel_we && (w_sel_size == c_SZ_WORD)) begin
                  w_state_nxt = S_WR;
               end else begin
                  // loads and sub-word stores both need the current word
                  w_state_nxt = S_RD;
               end
            end
         end

         S_RD: begin
            o_mem_a     = {r_addr[31:2], 2'b00};
            o_mem_pc    = r_pc;
            w_state_nxt = r_we ? S_WR : S_ACK;
         end

         S_WR: begin
            o_mem_a     = {r_addr[31:2], 2'b00};
            o_mem_pc    = r_pc;
            o_mem_we    = 1'b1;
            o_mem_wd    = (r_size == c_SZ_WORD) ? r_wd : w_merge;
            w_state_nxt = S_ACK;
         end

         S_ACK: begin
            if (r_owner == c_OWNER_D) begin
               o_d_ack   = 1'b1;
               o_d_err   = r_err;
               o_d_rdata = w_rdata;
            end else begin
               o_c_ack   = 1'b1;
               o_c_err   = r_err;
               o_c_rdata = w_rdata;
            end
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Optional write / error trace
   // -------------------------------------------------------------------------
`ifdef DM_ARBITER_TRACE_EN
   always @(posedge clk) begin
      if (rst_n && (r_state == S_WR)) begin
         $display("%d@%h: *%h <= %h", $time, r_pc, {r_addr[31:2], 2'b00}, o_mem_wd);
      end
      if (rst_n && (r_state == S_ACK) && r_err) begin
         $display("%d@%h: dm err %h", $time, r_pc, r_addr);
      end
   end
`else
   // trace disabled: no simulation output
`endif

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dm_arbiter
//  Description : Self-checking bench for dm_arbiter. Directed scenarios
//                followed by randomized transactions, compared against a
//                behavioural word-memory model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dm_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        c_req, c_we, d_req, d_we;
   logic [1:0]  c_size, d_size;
   logic [31:0] c_addr, c_wd, c_pc, d_addr, d_wd, d_pc;
   logic        c_ack, c_err, d_ack, d_err;
   logic [31:0] c_rdata, d_rdata;
   logic [31:0] mem_a, mem_wd, mem_pc, mem_rd;
   logic        mem_we, busy;

   // environment memory (what the DUT drives) and preload path
   logic [31:0] env_mem [0:1023];
   logic        pre_we;
   logic [9:0]  pre_idx;
   logic [31:0] pre_data;

   // reference model memory
   logic [31:0] ref_mem [0:1023];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we)      env_mem[mem_a[11:2]] <= mem_wd;
      else if (pre_we) env_mem[pre_idx]     <= pre_data;
   end
   assign mem_rd = env_mem[mem_a[11:2]];

   dm_arbiter #(.MEM_BYTES(4096), .RESET_PRIO(1'b0)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_c_req  (c_req),  .i_c_we (c_we), .i_c_size (c_size),
      .i_c_addr (c_addr), .i_c_wd (c_wd), .i_c_pc   (c_pc),
      .o_c_ack  (c_ack),  .o_c_err(c_err), .o_c_rdata(c_rdata),
      .i_d_req  (d_req),  .i_d_we (d_we), .i_d_size (d_size),
      .i_d_addr (d_addr), .i_d_wd (d_wd), .i_d_pc   (d_pc),
      .o_d_ack  (d_ack),  .o_d_err(d_err), .o_d_rdata(d_rdata),
      .o_mem_a  (mem_a),
      .o_mem_we (mem_we),
      .o_mem_wd (mem_wd),
      .o_mem_pc (mem_pc),
      .i_mem_rd (mem_rd),
      .o_busy   (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---- reference model -----------------------------------------------------
   function automatic bit model_err(input logic [1:0] sz, input logic [31:0] a);
      return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0)
          || (sz == 2'd2 && (a % 4) != 0) || (a >= 32'd4096);
   endfunction

   function automatic logic [31:0] model_load(input logic [1:0] sz, input logic [31:0] a);
      logic [31:0] w;
      w = ref_mem[a / 4];
      if (sz == 2'd0)      return (w >> (8 * (a % 4))) & 32'h0000_00FF;
      else if (sz == 2'd1) return (w >> (16 * ((a % 4) / 2))) & 32'h0000_FFFF;
      else                 return w;
   endfunction

   function automatic logic [31:0] model_store(input logic [1:0] sz, input logic [31:0] a,
                                               input logic [31:0] wd);
      logic [31:0] w, mask;
      int sh;
      w = ref_mem[a / 4];
      if (sz == 2'd0) begin
         sh = 8 * int'(a % 4);
         mask = 32'h0000_00FF << sh;
         return (w & ~mask) | ((wd & 32'h0000_00FF) << sh);
      end else if (sz == 2'd1) begin
         sh = 16 * int'((a % 4) / 2);
         mask = 32'h0000_FFFF << sh;
         return (w & ~mask) | ((wd & 32'h0000_FFFF) << sh);
      end
      return wd;
   endfunction

   // ---- stimulus helpers -----------------------------------------------------
   task automatic drive(input bit port, input bit req, input bit we, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pc);
      if (port == 1'b0) begin
         c_req = req; c_we = we; c_size = sz; c_addr = a; c_wd = wd; c_pc = pc;
      end else begin
         d_req = req; d_we = we; d_size = sz; d_addr = a; d_wd = wd; d_pc = pc;
      end
   endtask

   task automatic drop_req(input bit port);
      if (port == 1'b0) c_req = 1'b0;
      else              d_req = 1'b0;
   endtask

   // One transaction, starting at a negedge with the DUT idle.
   task automatic txn(input bit port, input bit we, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] pc, input bit drop);
      bit          e;
      int          lat;
      int          nwe;
      logic [31:0] exp_rd, neww;
      logic        own_ack, own_err, oth_ack, oth_err;
      logic [31:0] own_rd, oth_rd;

      e      = model_err(sz, a);
      lat    = e ? 1 : ((!we || sz == 2'd2) ? 2 : 3);
      exp_rd = (e || we) ? 32'd0 : model_load(sz, a);
      neww   = (e || !we) ? 32'd0 : model_store(sz, a, wd);
      nwe    = 0;
      drive(port, 1'b1, we, sz, a, wd, pc);

      for (int k = 1; k <= lat + 1; k++) begin
         @(posedge clk);
         @(negedge clk);
         own_ack = port ? d_ack   : c_ack;
         own_err = port ? d_err   : c_err;
         own_rd  = port ? d_rdata : c_rdata;
         oth_ack = port ? c_ack   : d_ack;
         oth_err = port ? c_err   : d_err;
         oth_rd  = port ? c_rdata : d_rdata;

         check("ack_timing", 32'(own_ack), 32'(k == lat));
         check("other_port_quiet", {30'd0, oth_ack, oth_err} | oth_rd, 32'd0);
         if (mem_we) begin
            nwe++;
            check("wr_addr", mem_a, a & 32'hFFFF_FFFC);
            check("wr_data", mem_wd, neww);
            check("wr_pc", mem_pc, pc);
         end
         if (k == lat) begin
            check("err_flag", 32'(own_err), 32'(e));
            if (!we || e) check("load_rdata", own_rd, exp_rd);
            drop_req(port);
         end
         if (drop && k == 1) drop_req(port);
         if (k == lat + 1) check("idle_after_ack", 32'(busy), 32'd0);
      end
      check("we_pulses", 32'(nwe), (we && !e) ? 32'd1 : 32'd0);
      if (we && !e) ref_mem[a / 4] = neww;
   endtask

   // ---- watchdog -------------------------------------------------------------
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---- main sequence --------------------------------------------------------
   initial begin
      rst_n = 1'b0;
      pre_we = 1'b0; pre_idx = 10'd0; pre_data = 32'd0;
      drive(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0);
      drive(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0);
      for (int i = 0; i < 1024; i++) ref_mem[i] = 32'd0;

      @(negedge clk);
      // reset state
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_acks", {28'd0, c_ack, c_err, d_ack, d_err}, 32'd0);
      check("rst_c_rdata", c_rdata, 32'd0);
      check("rst_d_rdata", d_rdata, 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_a", mem_a, 32'd0);
      check("rst_mem_wd", mem_wd, 32'd0);
      check("rst_mem_pc", mem_pc, 32'd0);

      // preload the first 64 words while reset is held
      for (int i = 0; i < 64; i++) begin
         pre_we   = 1'b1;
         pre_idx  = 10'(i);
         pre_data = (i == 8) ? 32'h1122_3344 : $urandom;
         ref_mem[i] = pre_data;
         @(negedge clk);
      end
      pre_we = 1'b0;

      // contention from reset: both held, expect C, D, C, D
      drive(1'b0, 1'b1, 1'b0, 2'd2, 32'h0000_0000, 32'd0, 32'h100);
      drive(1'b1, 1'b1, 1'b0, 2'd2, 32'h0000_0004, 32'd0, 32'h200);
      rst_n = 1'b1;
      for (int g = 0; g < 4; g++) begin
         bit expd;
         bit seen;
         expd = (g % 2) == 1;
         seen = 1'b0;
         for (int t = 0; t < 6 && !seen; t++) begin
            @(posedge clk);
            @(negedge clk);
            if (c_ack || d_ack) seen = 1'b1;
         end
         check("contention_ack_seen", 32'(seen), 32'd1);
         check("contention_owner", {30'd0, c_ack, d_ack}, expd ? 32'd1 : 32'd2);
         check("contention_rdata", expd ? d_rdata : c_rdata, expd ? ref_mem[1] : ref_mem[0]);
         check("contention_other_rdata", expd ? c_rdata : d_rdata, 32'd0);
      end
      c_req = 1'b0;
      d_req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("contention_idle", 32'(busy), 32'd0);

      // word store then load, port C
      txn(1'b0, 1'b1, 2'd2, 32'h10, 32'hDEAD_BEEF, 32'h400, 1'b0);
      txn(1'b0, 1'b0, 2'd2, 32'h10, 32'd0, 32'h404, 1'b0);
      check("word_store_mem", env_mem[4], 32'hDEAD_BEEF);

      // byte read-modify-write then half load
      txn(1'b0, 1'b1, 2'd0, 32'h22, 32'h0000_00AB, 32'h408, 1'b0);
      check("byte_rmw_mem", env_mem[8], 32'h11AB_3344);
      txn(1'b0, 1'b0, 2'd1, 32'h22, 32'd0, 32'h40C, 1'b0);

      // errors: misaligned half, misaligned/out-of-range word, illegal size,
      // first out-of-range address
      txn(1'b0, 1'b0, 2'd1, 32'h13,   32'd0, 32'h500, 1'b0);
      txn(1'b1, 1'b1, 2'd2, 32'h1002, 32'h1234_5678, 32'h504, 1'b0);
      txn(1'b0, 1'b1, 2'd3, 32'h08,   32'hFFFF_FFFF, 32'h508, 1'b0);
      txn(1'b1, 1'b0, 2'd2, 32'h1000, 32'd0, 32'h50C, 1'b0);
      txn(1'b1, 1'b0, 2'd2, 32'h0FFC, 32'd0, 32'h510, 1'b0);

      // reset during RD of a byte store
      drive(1'b0, 1'b1, 1'b1, 2'd0, 32'h25, 32'h0000_005A, 32'h600);
      @(posedge clk);
      @(negedge clk);
      check("midop_busy", 32'(busy), 32'd1);
      check("midop_rd_addr", mem_a, 32'h24);
      check("midop_rd_no_we", 32'(mem_we), 32'd0);
      #2;
      rst_n = 1'b0;
      c_req = 1'b0;
      #1;
      check("midop_reset_busy", 32'(busy), 32'd0);
      check("midop_reset_we", 32'(mem_we), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("midop_no_ack", {30'd0, c_ack, mem_we}, 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      check("midop_mem_unchanged", env_mem[9], ref_mem[9]);
      txn(1'b0, 1'b0, 2'd2, 32'h24, 32'd0, 32'h604, 1'b0);

      // requester drops req one cycle after grant
      txn(1'b0, 1'b1, 2'd0, 32'h31, 32'h0000_00C3, 32'h700, 1'b1);
      txn(1'b1, 1'b0, 2'd1, 32'h32, 32'd0, 32'h704, 1'b1);

      // randomized traffic
      for (int i = 0; i < 60; i++) begin
         bit          port, we, drop;
         logic [1:0]  sz;
         logic [31:0] a;
         port = 1'($urandom_range(0, 1));
         we   = 1'($urandom_range(0, 1));
         drop = ($urandom_range(0, 3) == 0);
         sz   = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) a = $urandom | 32'h0000_1000;
         else                           a = 32'($urandom_range(0, 255));
         txn(port, we, sz, a, $urandom, $urandom, drop);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
